// File: rtl/bat_amateur_pkg.sv
// -----------------------------------------------------------------------------
// bat_amateur_pkg
// Shared definitions for the program loader: word/address widths, the RAM
// read/write polarity constant and the loader state encoding.
// -----------------------------------------------------------------------------
package bat_amateur_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;

    // Level on EXT_RAM_RW that selects a RAM write on the target board.
    localparam logic RAM_WR_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
        ST_SETUP  = 3'd5,
        ST_STROBE = 3'd6,
        ST_FINISH = 3'd7
    } loader_state_e;

endpackage

// File: rtl/byte_pair_assembler.sv
// -----------------------------------------------------------------------------
// byte_pair_assembler
// Captures the high byte of a big-endian pair and presents the merged 16-bit
// word while the low byte is on the input, so the caller can register the
// word on the same edge that accepts the low byte.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   hi_load  in   capture byte_in as the high byte on this edge
//   byte_in  in   current serial byte (the low byte when the word is used)
//   word     out  {captured high byte, byte_in}
// -----------------------------------------------------------------------------
module byte_pair_assembler
    import bat_amateur_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hi_load,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word
);

    logic [7:0] hi_r;

    // High-byte holding register, loaded when the loader accepts a HI byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= 8'h00;
        end else if (hi_load) begin
            hi_r <= byte_in;
        end else begin
            hi_r <= hi_r;
        end
    end

    assign word = {hi_r, byte_in};

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a length-prefixed, big-endian byte stream and writes the words to
// external RAM starting at BASE_ADDR while holding the CPU in HALT.
// Each word is presented for one SETUP cycle, then strobed for exactly one
// STROBE cycle with address, data and direction held stable.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-low reset
//   START       in   begin a load (only honoured in IDLE)
//   BYTE_IN     in   serial program byte
//   BYTE_VALID  in   BYTE_IN valid
//   BYTE_READY  out  loader accepts BYTE_IN this cycle
//   HALT        out  CPU held, RAM owned by loader
//   ADDRESS     out  RAM write address
//   DATA        out  RAM write data
//   EXT_RAM_EN  out  RAM enable strobe
//   EXT_RAM_RW  out  RAM direction (WR_LEVEL = write)
//   DONE        out  one-cycle pulse at the end of a load
// -----------------------------------------------------------------------------
module prog_loader
    import bat_amateur_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter logic              WR_LEVEL  = RAM_WR_LEVEL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              HALT,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [WORD_W-1:0] DATA,
    output logic              EXT_RAM_EN,
    output logic              EXT_RAM_RW,
    output logic              DONE
);

    loader_state_e     state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] rem_r;
    logic [WORD_W-1:0] word_s;
    logic              xfer_s;
    logic              hi_load_s;

    // A byte moves only when both sides agree on the same edge.
    assign xfer_s    = BYTE_VALID & BYTE_READY;
    assign hi_load_s = xfer_s & ((state_r == ST_LEN_HI) | (state_r == ST_DAT_HI));

    byte_pair_assembler u_asm (
        .clk     (CLK),
        .rst_n   (RST),
        .hi_load (hi_load_s),
        .byte_in (BYTE_IN),
        .word    (word_s)
    );

    // Loader FSM with registered outputs, address counter and word counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= ST_IDLE;
            HALT       <= 1'b0;
            BYTE_READY <= 1'b0;
            EXT_RAM_EN <= 1'b0;
            EXT_RAM_RW <= ~WR_LEVEL;
            DONE       <= 1'b0;
            ADDRESS    <= BASE_ADDR;
            DATA       <= 16'h0000;
            addr_r     <= BASE_ADDR;
            rem_r      <= 16'h0000;
        end else begin
            // DONE and the strobe are single-cycle; re-asserted explicitly below.
            DONE       <= 1'b0;
            EXT_RAM_EN <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r    <= ST_LEN_HI;
                        HALT       <= 1'b1;
                        BYTE_READY <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer_s) begin
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_s) begin
                        if (word_s == 16'h0000) begin
                            state_r    <= ST_FINISH;
                            BYTE_READY <= 1'b0;
                            DONE       <= 1'b1;
                        end else begin
                            state_r <= ST_DAT_HI;
                            addr_r  <= BASE_ADDR;
                            rem_r   <= word_s;
                        end
                    end
                end
                ST_DAT_HI: begin
                    if (xfer_s) begin
                        state_r <= ST_DAT_LO;
                    end
                end
                ST_DAT_LO: begin
                    if (xfer_s) begin
                        state_r    <= ST_SETUP;
                        BYTE_READY <= 1'b0;
                        ADDRESS    <= addr_r;
                        DATA       <= word_s;
                        EXT_RAM_RW <= WR_LEVEL;
                    end
                end
                ST_SETUP: begin
                    state_r    <= ST_STROBE;
                    EXT_RAM_EN <= 1'b1;
                end
                ST_STROBE: begin
                    // Direction returns to idle level only once the strobe ends.
                    EXT_RAM_RW <= ~WR_LEVEL;
                    if (rem_r == 16'd1) begin
                        state_r <= ST_FINISH;
                        DONE    <= 1'b1;
                    end else begin
                        state_r    <= ST_DAT_HI;
                        addr_r     <= addr_r + 16'd1;
                        rem_r      <= rem_r - 16'd1;
                        BYTE_READY <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                    HALT    <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    HALT       <= 1'b0;
                    BYTE_READY <= 1'b0;
                    EXT_RAM_RW <= ~WR_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: RAM address of the first loaded word.
REQ-002 Parameter WR_LEVEL, default 1'b0: EXT_RAM_RW level that selects a RAM write.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 START  in  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 BYTE_IN  in  8  serial-side program byte.
REQ-007 BYTE_VALID  in  1  BYTE_IN is valid.
REQ-008 BYTE_READY  out  1  loader accepts BYTE_IN this cycle.
REQ-009 HALT  out  1  holds the CPU and hands RAM to the loader.
REQ-010 ADDRESS  out  16  RAM address during a write.
REQ-011 DATA  out  16  RAM write word, driven onto the CPU bus while HALT=1.
REQ-012 EXT_RAM_EN  out  1  RAM enable strobe.
REQ-013 EXT_RAM_RW  out  1  RAM direction.
REQ-014 DONE  out  1  one-cycle pulse when a load completes.

Function
REQ-015 A byte transfers on a rising edge where BYTE_VALID=1 and BYTE_READY=1; no other edge consumes a byte.
REQ-016 Stream format, big-endian: LEN_HI, LEN_LO (16-bit word count N), then N words, each sent as HI byte then LO byte.
REQ-017 States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, SETUP, STROBE, FINISH.
REQ-018 IDLE: HALT=0, BYTE_READY=0; START=1 -> LEN_HI, with HALT=1 from the next cycle.
REQ-019 BYTE_READY=1 only in LEN_HI, LEN_LO, DAT_HI and DAT_LO; each of these states advances on a transfer and holds otherwise.
REQ-020 LEN_LO transfer: N=0 -> FINISH; otherwise -> DAT_HI with the address counter set to BASE_ADDR.
REQ-021 DAT_LO transfer -> SETUP: ADDRESS and DATA hold the current address and assembled word, EXT_RAM_EN=0, EXT_RAM_RW=WR_LEVEL.
REQ-022 STROBE: exactly one cycle with EXT_RAM_EN=1, with ADDRESS, DATA and EXT_RAM_RW unchanged from SETUP.
REQ-023 After STROBE: remaining count 1 -> FINISH; otherwise address+1 and remaining-1 -> DAT_HI.
REQ-024 Address increments modulo 2^16: 16'hFFFF wraps to 16'h0000 with no error.
REQ-025 FINISH: HALT=1 and DONE=1 for one cycle, then -> IDLE, so HALT=0 on the following cycle.
REQ-026 START outside IDLE is ignored.
REQ-027 BYTE_VALID stalls of any length between bytes are legal; outputs hold while stalled.
REQ-028 Outside SETUP/STROBE: EXT_RAM_EN=0 and EXT_RAM_RW=~WR_LEVEL.
REQ-029 All outputs are registered.

Reset
REQ-030 RST=0 immediately forces IDLE, HALT=0, BYTE_READY=0, EXT_RAM_EN=0, EXT_RAM_RW=~WR_LEVEL, DONE=0, ADDRESS=BASE_ADDR, DATA=0, and clears the counters.
REQ-031 Reset during a load abandons it: no further RAM strobe and no DONE; already-written words stay in RAM.

Structure
REQ-032 Shared package bat_amateur_pkg holds the loader state encoding, the RAM RW polarity constant and the 16-bit word/address widths.
REQ-033 One sub-module, byte_pair_assembler, merges two accepted bytes into a 16-bit word; the FSM, address counter and word counter stay in prog_loader.

Verification
REQ-034 START; bytes 00 02 12 34 AB CD -> writes 16'h1234@0000 then 16'hABCD@0001, one EN pulse each, one DONE pulse, then HALT=0.
REQ-035 START; bytes 00 00 -> no EXT_RAM_EN pulse; DONE one cycle after LEN_LO; HALT=0 the following cycle.
REQ-036 BASE_ADDR=16'hFFFF, N=2, words 0001 0002 -> writes at FFFF then 0000.
REQ-037 BYTE_VALID low for 5 cycles between HI and LO -> BYTE_READY stays 1, no strobe; the word is written once after LO arrives.
REQ-038 RST=0 asserted in DAT_LO of word 2 of 3 -> outputs take reset values asynchronously, no DONE; a new START then reloads correctly.
REQ-039 START pulsed during a load -> ignored; exactly N strobes and one DONE.
